// File: rtl/alu_iter_pkg.sv
// alu_iter_pkg -- shared definitions for the iterative ALU.
//   * 5-bit op-code constants
//   * FSM state type (DIV state present only when ALU_ITER_DIV_EN is defined)
//   * op_class(): classifies an op code as base / mul / div / illegal
// Configuration macro: ALU_ITER_DIV_EN (enables the divide op group).
package alu_iter_pkg;

    localparam logic [4:0] OP_ADD    = 5'h00;
    localparam logic [4:0] OP_SUB    = 5'h01;
    localparam logic [4:0] OP_AND    = 5'h02;
    localparam logic [4:0] OP_OR     = 5'h03;
    localparam logic [4:0] OP_XOR    = 5'h04;
    localparam logic [4:0] OP_SLL    = 5'h05;
    localparam logic [4:0] OP_SRL    = 5'h06;
    localparam logic [4:0] OP_SRA    = 5'h07;
    localparam logic [4:0] OP_EQ     = 5'h08;
    localparam logic [4:0] OP_LTU    = 5'h09;
    localparam logic [4:0] OP_LT     = 5'h0A;
    localparam logic [4:0] OP_GEU    = 5'h0B;
    localparam logic [4:0] OP_GE     = 5'h0C;
    localparam logic [4:0] OP_JALR   = 5'h0D;
    localparam logic [4:0] OP_MUL    = 5'h10;
    localparam logic [4:0] OP_MULH   = 5'h11;
    localparam logic [4:0] OP_MULHSU = 5'h12;
    localparam logic [4:0] OP_MULHU  = 5'h13;
    localparam logic [4:0] OP_DIV    = 5'h14;
    localparam logic [4:0] OP_DIVU   = 5'h15;
    localparam logic [4:0] OP_REM    = 5'h16;
    localparam logic [4:0] OP_REMU   = 5'h17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
`ifdef ALU_ITER_DIV_EN
        DIV  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_BASE = 2'd0,
        CLS_MUL  = 2'd1,
        CLS_DIV  = 2'd2,
        CLS_ILL  = 2'd3
    } op_class_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        if (op <= OP_JALR)
            return CLS_BASE;
        else if (op >= OP_MUL && op <= OP_MULHU)
            return CLS_MUL;
`ifdef ALU_ITER_DIV_EN
        else if (op >= OP_DIV && op <= OP_REMU)
            return CLS_DIV;
`endif
        else
            return CLS_ILL;
    endfunction

endpackage

// File: rtl/alu_iter_base.sv
// alu_iter_base -- combinational single-cycle ops (0x00-0x0D).
// Ports:
//   op     [4:0]       operation code
//   a, b   [XLEN-1:0]  operands
//   result [XLEN-1:0]  op result (0 for codes outside the base group)
module alu_iter_base
    import alu_iter_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [SHW-1:0]         sh;
    logic [XLEN-1:0]        sum;

    assign a_s = a;
    assign b_s = b;
    assign sh  = b[SHW-1:0];
    assign sum = a + b;

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = sum;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = a << sh;
            OP_SRL:  result = a >> sh;
            OP_SRA:  result = a_s >>> sh;
            OP_EQ:   result = {{(XLEN-1){1'b0}}, (a == b)};
            OP_LTU:  result = {{(XLEN-1){1'b0}}, (a < b)};
            OP_LT:   result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            OP_GEU:  result = {{(XLEN-1){1'b0}}, (a >= b)};
            OP_GE:   result = {{(XLEN-1){1'b0}}, (a_s >= b_s)};
            OP_JALR: result = {sum[XLEN-1:1], 1'b0};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_iter.sv
// alu_iter -- iterative ALU: single-cycle base ops, shift-add multiply,
// restoring divide (optional), valid/ready handshake on both sides.
// Configuration macro: ALU_ITER_DIV_EN (defined: DIV/DIVU/REM/REMU supported;
// undefined: divider absent and those codes report err).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 synchronous abort of in-flight / unconsumed work
//   in_valid, in_ready    request handshake; op/a/b captured on accept
//   out_valid, out_ready  result handshake; result/err held until taken
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            err
);

    state_t              state;
    logic [SHW-1:0]      cnt;
    logic [2*XLEN-1:0]   acc;     // mul: product; div: {remainder, quotient}
    logic [2*XLEN-1:0]   mcand;   // mul: shifting multiplicand; div: divisor in low half
    logic [XLEN-1:0]     mplier;
    logic                sel;     // mul: return high half; div: return remainder
    logic                neg;     // negate final magnitude

    logic [XLEN-1:0]     base_res;
    op_class_t           cls;
    logic                accept;
    logic                sgn_a, sgn_b, a_neg, b_neg, sel_in, neg_in;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic [2*XLEN-1:0]   mul_acc, mul_fin;
    logic [XLEN-1:0]     mul_res;

    alu_iter_base #(.XLEN(XLEN), .SHW(SHW)) u_base (
        .op     (op),
        .a      (a),
        .b      (b),
        .result (base_res)
    );

    assign cls      = op_class(op);
    assign in_ready = rst_n && !flush &&
                      ((state == IDLE) || (state == DONE && out_ready));
    assign accept   = in_valid && in_ready;

    // Operand signedness and magnitudes, evaluated on the accept cycle.
    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        case (op)
            OP_MULH, OP_DIV, OP_REM: begin sgn_a = 1'b1; sgn_b = 1'b1; end
            OP_MULHSU:               sgn_a = 1'b1;
            default:                 ;
        endcase
    end

    assign a_neg  = sgn_a && a[XLEN-1];
    assign b_neg  = sgn_b && b[XLEN-1];
    assign mag_a  = a_neg ? -a : a;
    assign mag_b  = b_neg ? -b : b;
    assign sel_in = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU) ||
                    (op == OP_REM)  || (op == OP_REMU);
    // Remainder takes the dividend's sign; everything else the xor of signs.
    assign neg_in = ((op == OP_REM) || (op == OP_REMU)) ? a_neg : (a_neg ^ b_neg);

    // One shift-add step; the final step's value feeds the result directly.
    assign mul_acc = acc + (mplier[0] ? mcand : '0);
    assign mul_fin = neg ? -mul_acc : mul_acc;
    assign mul_res = sel ? mul_fin[2*XLEN-1:XLEN] : mul_fin[XLEN-1:0];

`ifdef ALU_ITER_DIV_EN
    logic                div_zero, div_ovf;
    logic [XLEN-1:0]     div_bypass, div_q, div_r, div_res;
    logic [XLEN:0]       rem_shift, diff;
    logic [2*XLEN-1:0]   div_acc;

    assign div_zero   = (b == '0);
    assign div_ovf    = sgn_b && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign div_bypass = div_zero ? (sel_in ? a : '1) : (sel_in ? '0 : a);

    // Restoring step: shift next dividend bit into the partial remainder and
    // keep the subtraction only if it did not go negative.
    assign rem_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign diff      = rem_shift - {1'b0, mcand[XLEN-1:0]};
    assign div_acc   = diff[XLEN] ? {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                  : {diff[XLEN-1:0],      acc[XLEN-2:0], 1'b1};
    assign div_q     = div_acc[XLEN-1:0];
    assign div_r     = div_acc[2*XLEN-1:XLEN];
    assign div_res   = sel ? (neg ? -div_r : div_r) : (neg ? -div_q : div_q);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            err       <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            sel       <= 1'b0;
            neg       <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        cnt <= '0;
                        sel <= sel_in;
                        neg <= neg_in;
                        case (cls)
                            CLS_BASE: begin
                                result    <= base_res;
                                err       <= 1'b0;
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end
                            CLS_MUL: begin
                                acc       <= '0;
                                mcand     <= {{XLEN{1'b0}}, mag_a};
                                mplier    <= mag_b;
                                out_valid <= 1'b0;
                                state     <= MUL;
                            end
`ifdef ALU_ITER_DIV_EN
                            CLS_DIV: begin
                                if (div_zero || div_ovf) begin
                                    result    <= div_bypass;
                                    err       <= 1'b0;
                                    out_valid <= 1'b1;
                                    state     <= DONE;
                                end else begin
                                    acc       <= {{XLEN{1'b0}}, mag_a};
                                    mcand     <= {{XLEN{1'b0}}, mag_b};
                                    out_valid <= 1'b0;
                                    state     <= DIV;
                                end
                            end
`endif
                            default: begin
                                result    <= '0;
                                err       <= 1'b1;
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end
                        endcase
                    end else if (state == DONE && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                MUL: begin
                    acc    <= mul_acc;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (&cnt) begin
                        result    <= mul_res;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
`ifdef ALU_ITER_DIV_EN
                DIV: begin
                    acc <= div_acc;
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        result    <= div_res;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits; SHALL be a power of two, 8 to 64.
REQ-002 Parameter SHW, default $clog2(XLEN), shift-amount width; SHALL be derived from XLEN and not overridden.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-005 flush  input  1  synchronous abort of any in-flight or pending operation.
REQ-006 in_valid  input  1  operation request present.
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 op  input  5  operation code per REQ-013.
REQ-009 a, b  input  XLEN each  operands.
REQ-010 out_valid  output  1  result register holds an unconsumed result.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 result  output  XLEN; err  output  1  result value and illegal-op flag.

Function
REQ-013 Ops SHALL be: 0x00 add, 01 sub, 02 and, 03 or, 04 xor, 05 sll, 06 srl, 07 sra, 08 eq, 09 ltu, 0A lt, 0B geu, 0C ge, 0D jalr-add (a+b with bit0 cleared), 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU; all others illegal.
REQ-014 Shifts SHALL use b[SHW-1:0] only; compares SHALL return 1 or 0 zero-extended to XLEN.
REQ-015 FSM states SHALL be IDLE, MUL, DIV, DONE.
REQ-016 Accept occurs when in_valid && in_ready; in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready), and SHALL be 0 while flush is high.
REQ-017 Ops 0x00-0x0D and illegal ops SHALL go to DONE with result registered the cycle after accept (latency 1).
REQ-018 Illegal ops SHALL produce result 0, err 1; all legal ops SHALL produce err 0.
REQ-019 MUL* SHALL run shift-add one bit per cycle on operand magnitudes, XLEN cycles in MUL, then DONE (latency XLEN+1); signed forms SHALL negate the 2*XLEN product when operand signs differ.
REQ-020 MUL SHALL return low XLEN bits; MULH/MULHSU/MULHU SHALL return high XLEN bits with a,b treated signed/signed, signed/unsigned, unsigned/unsigned.
REQ-021 DIV* SHALL run restoring division one bit per cycle, XLEN cycles in DIV, then DONE (latency XLEN+1); quotient sign = sign(a) xor sign(b), remainder sign = sign(a).
REQ-022 Divide by zero SHALL bypass DIV with latency 1: quotient all ones, remainder = a.
REQ-023 Signed overflow (a = most-negative, b = -1) SHALL bypass with latency 1: DIV = a, REM = 0.
REQ-024 In DONE, out_valid=1 and result/err SHALL hold stable until out_ready; on out_ready without new accept, next state IDLE, out_valid 0.
REQ-025 Accept in DONE concurrent with out_ready SHALL retire the old result and start the new op the same cycle (back-to-back 1-cycle ops give one result per cycle).
REQ-026 Operands SHALL be captured at accept; a, b, op changes afterwards SHALL not affect the result.
REQ-027 flush SHALL force IDLE, out_valid 0 next cycle, discarding any in-flight or unconsumed result; flush dominates in_valid and out_ready.

Reset
REQ-028 While rst_n low: state IDLE, out_valid 0, result 0, err 0, internal counters/accumulators 0; in_ready SHALL be 0 while rst_n is low.
REQ-029 Reset asserted mid-MUL/DIV SHALL abort with no result emitted after release.

Configuration
REQ-030 Macro ALU_ITER_DIV_EN: defined, ops 0x14-0x17 behave per REQ-021..023; undefined, the DIV state and divider logic SHALL be absent and 0x14-0x17 SHALL be treated as illegal (REQ-018).

Structure
REQ-031 Package alu_iter_pkg SHALL hold the op-code constants, FSM state typedef, and op-class helper (base/mul/div/illegal).
REQ-032 Single-cycle ops SHALL live in one combinational sub-module alu_iter_base; sequencing and mul/div datapath in alu_iter.

Verification
REQ-033 add a=0xFFFFFFFF b=1, out_ready=1 -> out_valid one cycle after accept, result 0x00000000, err 0.
REQ-034 MULH a=0x80000000 b=0x80000000 -> out_valid exactly 33 cycles after accept, result 0x40000000; MULHSU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-035 DIV a=0xFFFFFFF9 (-7) b=2 -> 0xFFFFFFFD after 33 cycles; REM same operands -> 0xFFFFFFFF; DIVU a=5 b=0 -> 0xFFFFFFFF after 1 cycle; DIV 0x80000000/-1 -> 0x80000000 after 1 cycle.
REQ-036 Hold out_ready=0 for 5 cycles after result -> result stable, in_ready 0; then out_ready=1 with in_valid=1 sub 10-3 -> next cycle result 7.
REQ-037 Assert flush at cycle 10 of a DIVU, and separately rst_n low mid-MUL -> out_valid never rises for that op; next op xor 0xF0^0xFF returns 0x0F.
REQ-038 Build without ALU_ITER_DIV_EN: REM a=9 b=4 -> result 0, err 1, latency 1; op 0x1F -> err 1 in both builds.
